// File: rtl/mem_access_pipe.sv
// mem_access_pipe: MEM stage with bus FSM, load lane extraction and store lane steering.
// Optional alignment trap is enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_access_pipe #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int REG_AW = 5
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                stall,
    input  logic                                flush,
    input  logic                                ex_en,
    input  logic [3:0]                          ex_mem_op,
    input  logic [DATA_W-1:0]                   ex_mem_wr_data,
    input  logic [ADDR_W-1:0]                   ex_out,
    input  logic [REG_AW-1:0]                   ex_dst_addr,
    input  logic                                ex_gpr_we_,
    output logic                                bus_req,
    output logic [ADDR_W-$clog2(DATA_W/8)-1:0]  bus_addr,
    output logic                                bus_rw,
    output logic [DATA_W/8-1:0]                 bus_be,
    output logic [DATA_W-1:0]                   bus_wr_data,
    input  logic                                bus_ack,
    input  logic [DATA_W-1:0]                   bus_rd_data,
    output logic                                busy,
    output logic [DATA_W-1:0]                   fwd_data,
    output logic                                mem_en,
    output logic [REG_AW-1:0]                   mem_dst_addr,
    output logic                                mem_gpr_we_,
    output logic [DATA_W-1:0]                   mem_out,
    output logic                                mem_miss_align
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int BA_W  = ADDR_W - OFF_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              req_q, req_d;
    logic [BA_W-1:0]   addr_q, addr_d;
    logic              rw_q, rw_d;
    logic [NB-1:0]     be_q, be_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic              ld_q, ld_d;
    logic [1:0]        sz_q, sz_d;
    logic              sgn_q, sgn_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [REG_AW-1:0] dst_q, dst_d;
    logic              we_q, we_d;
    logic              kill_q, kill_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              men_q, men_d;
    logic [REG_AW-1:0] mdst_q, mdst_d;
    logic              mwe_q, mwe_d;
    logic [DATA_W-1:0] mout_q, mout_d;
    logic              mis_q, mis_d;

    logic              dec_ld, dec_st, dec_sgn;
    logic [1:0]        dec_sz;
    logic [OFF_W-1:0]  lo_mask, off_al;
    logic              misal;
    logic [NB-1:0]     be_st;
    logic [DATA_W-1:0] wd_st, sh, ld_res;
    logic              bub, done;
    logic [DATA_W-1:0] done_val;

    always_comb begin
        dec_ld  = 1'b0;
        dec_st  = 1'b0;
        dec_sgn = 1'b0;
        dec_sz  = 2'd0;
        case (ex_mem_op)
            4'd1: begin dec_ld = 1'b1; dec_sgn = 1'b1; end
            4'd2: dec_ld = 1'b1;
            4'd3: begin dec_ld = 1'b1; dec_sgn = 1'b1; dec_sz = 2'd1; end
            4'd4: begin dec_ld = 1'b1; dec_sz = 2'd1; end
            4'd5: begin dec_ld = 1'b1; dec_sgn = 1'b1; dec_sz = 2'd2; end
            4'd6: dec_st = 1'b1;
            4'd7: begin dec_st = 1'b1; dec_sz = 2'd1; end
            4'd8: begin dec_st = 1'b1; dec_sz = 2'd2; end
            4'd9: if (DATA_W == 64) begin dec_ld = 1'b1; dec_sz = 2'd3; end
            4'd10: if (DATA_W == 64) begin dec_st = 1'b1; dec_sz = 2'd3; end
            default: dec_ld = 1'b0;
        endcase
    end

    assign lo_mask = OFF_W'((1 << dec_sz) - 1);
    assign off_al  = ex_out[OFF_W-1:0] & ~lo_mask;
`ifdef MEM_MISALIGN_TRAP_EN
    assign misal = (ex_out[OFF_W-1:0] & lo_mask) != '0;
`else
    assign misal = 1'b0;
`endif
    assign be_st = NB'((1 << (1 << dec_sz)) - 1) << off_al;

    // Store data is replicated into every lane; byte enables pick the target.
    always_comb begin
        case (dec_sz)
            2'd0:    wd_st = {NB{ex_mem_wr_data[7:0]}};
            2'd1:    wd_st = {(NB/2){ex_mem_wr_data[15:0]}};
            2'd2:    wd_st = {(NB/4){ex_mem_wr_data[31:0]}};
            default: wd_st = ex_mem_wr_data;
        endcase
    end

    assign sh = bus_rd_data >> {off_q, 3'b000};

    always_comb begin
        case (sz_q)
            2'd0: ld_res = sgn_q ? DATA_W'($signed(sh[7:0]))
                                 : DATA_W'(sh[7:0]);
            2'd1: ld_res = sgn_q ? DATA_W'($signed(sh[15:0]))
                                 : DATA_W'(sh[15:0]);
            2'd2: ld_res = sgn_q ? DATA_W'($signed(sh[31:0]))
                                 : DATA_W'(sh[31:0]);
            default: ld_res = sh;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        addr_d   = addr_q;
        rw_d     = rw_q;
        be_d     = be_q;
        wd_d     = wd_q;
        ld_d     = ld_q;
        sz_d     = sz_q;
        sgn_d    = sgn_q;
        off_d    = off_q;
        dst_d    = dst_q;
        we_d     = we_q;
        kill_d   = kill_q;
        buf_d    = buf_q;
        men_d    = men_q;
        mdst_d   = mdst_q;
        mwe_d    = mwe_q;
        mout_d   = mout_q;
        mis_d    = mis_q;
        busy     = 1'b0;
        fwd_data = DATA_W'(ex_out);
        bub      = 1'b0;
        done     = 1'b0;
        done_val = '0;
        unique case (state_q)
            S_IDLE: begin
                if (flush) begin
                    bub = 1'b1;
                end else if (!stall) begin
                    if (ex_en && (dec_ld || dec_st) && misal) begin
                        men_d  = 1'b1;
                        mdst_d = ex_dst_addr;
                        mwe_d  = 1'b1;
                        mout_d = DATA_W'(ex_out);
                        mis_d  = 1'b1;
                    end else if (ex_en && (dec_ld || dec_st)) begin
                        req_d   = 1'b1;
                        addr_d  = ex_out[ADDR_W-1:OFF_W];
                        rw_d    = dec_ld;
                        be_d    = dec_ld ? '1 : be_st;
                        wd_d    = wd_st;
                        ld_d    = dec_ld;
                        sz_d    = dec_sz;
                        sgn_d   = dec_sgn;
                        off_d   = off_al;
                        dst_d   = ex_dst_addr;
                        we_d    = ex_gpr_we_;
                        kill_d  = 1'b0;
                        state_d = S_BUSY;
                        busy    = 1'b1;
                        bub     = 1'b1;
                    end else begin
                        men_d  = ex_en;
                        mdst_d = ex_dst_addr;
                        mwe_d  = ex_gpr_we_ | ~ex_en;
                        mout_d = DATA_W'(ex_out);
                        mis_d  = 1'b0;
                    end
                end
            end
            S_BUSY: begin
                busy   = 1'b1;
                kill_d = kill_q | flush;
                if (bus_ack) begin
                    req_d    = 1'b0;
                    fwd_data = ld_res;
                    if (stall) begin
                        buf_d   = ld_q ? ld_res : '0;
                        state_d = S_HOLD;
                    end else begin
                        done     = 1'b1;
                        done_val = ld_q ? ld_res : '0;
                        busy     = 1'b0;
                        state_d  = S_IDLE;
                    end
                end
            end
            S_HOLD: begin
                busy     = 1'b1;
                kill_d   = kill_q | flush;
                fwd_data = buf_q;
                if (!stall) begin
                    done     = 1'b1;
                    done_val = buf_q;
                    busy     = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A flushed transaction still completes on the bus but retires as a bubble.
        if (done) begin
            if (kill_q || flush) begin
                bub = 1'b1;
            end else begin
                men_d  = 1'b1;
                mdst_d = dst_q;
                mwe_d  = ~ld_q | we_q;
                mout_d = done_val;
                mis_d  = 1'b0;
            end
        end
        if (bub) begin
            men_d  = 1'b0;
            mdst_d = '0;
            mwe_d  = 1'b1;
            mout_d = '0;
            mis_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            rw_q    <= 1'b1;
            be_q    <= '0;
            wd_q    <= '0;
            ld_q    <= 1'b0;
            sz_q    <= 2'd0;
            sgn_q   <= 1'b0;
            off_q   <= '0;
            dst_q   <= '0;
            we_q    <= 1'b1;
            kill_q  <= 1'b0;
            buf_q   <= '0;
            men_q   <= 1'b0;
            mdst_q  <= '0;
            mwe_q   <= 1'b1;
            mout_q  <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            be_q    <= be_d;
            wd_q    <= wd_d;
            ld_q    <= ld_d;
            sz_q    <= sz_d;
            sgn_q   <= sgn_d;
            off_q   <= off_d;
            dst_q   <= dst_d;
            we_q    <= we_d;
            kill_q  <= kill_d;
            buf_q   <= buf_d;
            men_q   <= men_d;
            mdst_q  <= mdst_d;
            mwe_q   <= mwe_d;
            mout_q  <= mout_d;
            mis_q   <= mis_d;
        end
    end

    assign bus_req        = req_q;
    assign bus_addr       = addr_q;
    assign bus_rw         = rw_q;
    assign bus_be         = be_q;
    assign bus_wr_data    = wd_q;
    assign mem_en         = men_q;
    assign mem_dst_addr   = mdst_q;
    assign mem_gpr_we_    = mwe_q;
    assign mem_out        = mout_q;
    assign mem_miss_align = mis_q;

endmodule

// File: tb/tb_mem_access_pipe.sv
// tb_mem_access_pipe: directed stimulus against a spec-level model of mem_access_pipe.
// Honours MEM_MISALIGN_TRAP_EN for the misaligned-word vector.
module tb_mem_access_pipe;

    localparam logic [3:0] NOP = 4'd0, LB = 4'd1, LBU = 4'd2, LH = 4'd3;
    localparam logic [3:0] LHU = 4'd4, LW = 4'd5, SB = 4'd6, SH = 4'd7;
    localparam logic [3:0] SW = 4'd8;

    logic        clk, reset, stall, flush, ex_en, ex_gpr_we_;
    logic [3:0]  ex_mem_op;
    logic [31:0] ex_mem_wr_data, ex_out, bus_wr_data, bus_rd_data;
    logic [4:0]  ex_dst_addr, mem_dst_addr;
    logic        bus_req, bus_rw, bus_ack, busy, mem_en, mem_gpr_we_;
    logic [29:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] fwd_data, mem_out;
    logic        mem_miss_align;

    mem_access_pipe dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .ex_en(ex_en), .ex_mem_op(ex_mem_op),
        .ex_mem_wr_data(ex_mem_wr_data), .ex_out(ex_out),
        .ex_dst_addr(ex_dst_addr), .ex_gpr_we_(ex_gpr_we_),
        .bus_req(bus_req), .bus_addr(bus_addr), .bus_rw(bus_rw),
        .bus_be(bus_be), .bus_wr_data(bus_wr_data), .bus_ack(bus_ack),
        .bus_rd_data(bus_rd_data), .busy(busy), .fwd_data(fwd_data),
        .mem_en(mem_en), .mem_dst_addr(mem_dst_addr),
        .mem_gpr_we_(mem_gpr_we_), .mem_out(mem_out),
        .mem_miss_align(mem_miss_align)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int busy_cnt = 0;

    logic        e_chk = 1'b0, e_rst = 1'b0, e_busy = 1'b0, e_req = 1'b0;
    logic        e_rw = 1'b1, e_fwd_chk = 1'b0;
    logic [29:0] e_addr = '0;
    logic [3:0]  e_be = '0;
    logic [31:0] e_wd = '0, e_fwd = '0;
    logic        m_en = 1'b0, m_we = 1'b1, m_mis = 1'b0;
    logic [4:0]  m_dst = '0;
    logic [31:0] m_out = '0;
    logic [29:0] cap_addr = '0;
    logic [3:0]  cap_be = '0;
    logic [31:0] cap_wd = '0;
    logic        cap_rw = 1'b1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [3:0] op);
        if (op == LB || op == LBU || op == SB) return 1;
        if (op == LH || op == LHU || op == SH) return 2;
        return 4;
    endfunction

    function automatic logic is_ld(input logic [3:0] op);
        return op >= LB && op <= LW;
    endfunction

    function automatic int lane(input logic [3:0] op, input logic [31:0] a);
        int n;
        n = nbytes(op);
        return (int'(a % 4) / n) * n;
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] rd);
        int n;
        logic [31:0] v, msk;
        n = nbytes(op);
        v = rd >> (8 * lane(op, a));
        msk = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
        v = v & msk;
        if ((op == LB || op == LH) && v[8*n-1]) v = v | ~msk;
        return v;
    endfunction

    function automatic logic [3:0] m_be(input logic [3:0] op,
                                        input logic [31:0] a);
        logic [3:0] b;
        if (is_ld(op)) return 4'hF;
        b = 4'((1 << nbytes(op)) - 1);
        return b << lane(op, a);
    endfunction

    function automatic logic [31:0] m_wd(input logic [3:0] op,
                                         input logic [31:0] d);
        if (nbytes(op) == 1) return {4{d[7:0]}};
        if (nbytes(op) == 2) return {2{d[15:0]}};
        return d;
    endfunction

    always @(negedge clk) begin
        if (e_chk) begin
            chk("busy", 64'(busy), 64'(e_busy));
            chk("bus_req", 64'(bus_req), 64'(e_req));
            if (e_req) begin
                chk("bus_addr", 64'(bus_addr), 64'(e_addr));
                chk("bus_rw", 64'(bus_rw), 64'(e_rw));
                chk("bus_be", 64'(bus_be), 64'(e_be));
                if (!e_rw) chk("bus_wr_data", 64'(bus_wr_data), 64'(e_wd));
                cap_addr = bus_addr;
                cap_be   = bus_be;
                cap_wd   = bus_wr_data;
                cap_rw   = bus_rw;
            end
            if (e_rst) begin
                chk("rst_rw", 64'(bus_rw), 64'd1);
                chk("rst_be", 64'(bus_be), 64'd0);
                chk("rst_addr", 64'(bus_addr), 64'd0);
                chk("rst_wd", 64'(bus_wr_data), 64'd0);
            end
            chk("mem_en", 64'(mem_en), 64'(m_en));
            chk("mem_dst", 64'(mem_dst_addr), 64'(m_dst));
            chk("mem_we_", 64'(mem_gpr_we_), 64'(m_we));
            chk("mem_out", 64'(mem_out), 64'(m_out));
            chk("miss_align", 64'(mem_miss_align), 64'(m_mis));
            if (e_fwd_chk) chk("fwd_data", 64'(fwd_data), 64'(e_fwd));
            if (busy) busy_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        m_en = 1'b0; m_dst = '0; m_we = 1'b1; m_out = '0; m_mis = 1'b0;
    endtask

    task automatic drive(input logic en, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] dst, input logic we);
        ex_en = en; ex_mem_op = op; ex_out = a; ex_mem_wr_data = wd;
        ex_dst_addr = dst; ex_gpr_we_ = we;
        stall = 1'b0; flush = 1'b0; bus_ack = 1'b0; bus_rd_data = '0;
    endtask

    task automatic nonmem(input logic en, input logic [31:0] v,
                          input logic [4:0] dst, input logic we);
        drive(en, 4'd12, v, 32'h0, dst, we);
        e_busy = 1'b0; e_req = 1'b0; e_fwd_chk = 1'b1; e_fwd = v;
        step();
        e_fwd_chk = 1'b0;
        m_en = en; m_dst = dst; m_we = we | ~en; m_out = v; m_mis = 1'b0;
    endtask

    // lat: BUSY cycles up to and including the ack; hold: stalled cycles from ack on
    task automatic access(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input logic [4:0] dst, input logic we,
                          input int lat, input int hold, input bit fl);
        logic ld;
        logic [31:0] res;
        ld  = is_ld(op);
        res = ld ? m_load(op, a, rd) : 32'h0;
        drive(1'b1, op, a, wd, dst, we);
        e_busy = 1'b1; e_req = 1'b0; e_fwd_chk = 1'b0;
        step();
        e_req = 1'b1; e_addr = a[31:2]; e_rw = ld;
        e_be = m_be(op, a); e_wd = m_wd(op, wd);
        bubble();
        for (int i = 1; i < lat; i++) begin
            flush = fl && (i == 1);
            step();
            flush = 1'b0;
        end
        bus_ack = 1'b1; bus_rd_data = rd;
        stall = (hold > 0); e_busy = (hold > 0);
        flush = fl && (lat == 1);
        e_fwd_chk = ld; e_fwd = res;
        step();
        bus_ack = 1'b0; bus_rd_data = '0; flush = 1'b0; e_req = 1'b0;
        if (hold > 0) begin
            e_busy = 1'b1;
            for (int i = 1; i < hold; i++) step();
            stall = 1'b0; e_busy = 1'b0;
            step();
        end
        e_fwd_chk = 1'b0;
        if (fl) bubble();
        else begin
            m_en = 1'b1; m_dst = dst; m_we = ~ld | we; m_out = res; m_mis = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        drive(1'b0, NOP, 32'h0, 32'h0, 5'd0, 1'b1);
        e_chk = 1'b1; e_rst = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
        e_rst = 1'b0;

        nonmem(1'b1, 32'hDEAD_BEEF, 5'd3, 1'b0);
        chk("nonmem_out", 64'(mem_out), 64'hDEAD_BEEF);
        nonmem(1'b0, 32'h0000_1234, 5'd7, 1'b0);

        busy_cnt = 0;
        access(LB, 32'h103, 32'h0, 32'h80FF_FFFF, 5'd9, 1'b0, 3, 0, 1'b0);
        chk("lb_out", 64'(mem_out), 64'hFFFF_FF80);
        chk("lb_busy_cycles", 64'(busy_cnt), 64'd3);
        chk("lb_en", 64'(mem_en), 64'd1);

        access(LBU, 32'h101, 32'h0, 32'h1122_A344, 5'd10, 1'b0, 1, 0, 1'b0);
        chk("lbu_out", 64'(mem_out), 64'h0000_00A3);
        access(LH, 32'h002, 32'h0, 32'h8001_7FFF, 5'd11, 1'b0, 2, 0, 1'b0);
        chk("lh_out", 64'(mem_out), 64'hFFFF_8001);
        access(LHU, 32'h000, 32'h0, 32'h8001_F00D, 5'd12, 1'b0, 1, 0, 1'b0);
        chk("lhu_out", 64'(mem_out), 64'h0000_F00D);

        access(SH, 32'h202, 32'h0000_1234, 32'h0, 5'd13, 1'b0, 2, 0, 1'b0);
        chk("sh_addr", 64'(cap_addr), 64'h80);
        chk("sh_be", 64'(cap_be), 64'hC);
        chk("sh_wd", 64'(cap_wd), 64'h1234_1234);
        chk("sh_rw", 64'(cap_rw), 64'd0);
        chk("sh_we_", 64'(mem_gpr_we_), 64'd1);
        access(SB, 32'h301, 32'h0000_00AB, 32'h0, 5'd14, 1'b0, 1, 0, 1'b0);
        chk("sb_be", 64'(cap_be), 64'h2);
        access(SW, 32'h400, 32'hCAFE_F00D, 32'h0, 5'd15, 1'b0, 2, 0, 1'b0);

        access(LW, 32'h010, 32'h0, 32'h1357_2468, 5'd16, 1'b0, 2, 3, 1'b0);
        chk("hold_out", 64'(mem_out), 64'h1357_2468);
        chk("hold_dst", 64'(mem_dst_addr), 64'd16);

        access(LW, 32'h020, 32'h0, 32'h5555_AAAA, 5'd17, 1'b0, 2, 0, 1'b1);
        chk("flush_en", 64'(mem_en), 64'd0);
        chk("flush_we_", 64'(mem_gpr_we_), 64'd1);

        nonmem(1'b1, 32'h0BAD_CAFE, 5'd18, 1'b0);
        drive(1'b1, LW, 32'h030, 32'h0, 5'd19, 1'b0);
        stall = 1'b1; e_busy = 1'b0; e_req = 1'b0;
        step();
        drive(1'b1, LW, 32'h030, 32'h0, 5'd19, 1'b0);
        flush = 1'b1;
        step();
        bubble();

`ifdef MEM_MISALIGN_TRAP_EN
        drive(1'b1, LW, 32'h102, 32'h0, 5'd20, 1'b0);
        step();
        m_en = 1'b1; m_dst = 5'd20; m_we = 1'b1; m_out = 32'h102; m_mis = 1'b1;
        chk("mis_flag", 64'(mem_miss_align), 64'd1);
        chk("mis_noreq", 64'(bus_req), 64'd0);
`else
        access(LW, 32'h102, 32'h0, 32'h0BAD_F00D, 5'd20, 1'b0, 1, 0, 1'b0);
        chk("unal_addr", 64'(cap_addr), 64'h40);
        chk("unal_out", 64'(mem_out), 64'h0BAD_F00D);
`endif

        drive(1'b1, LW, 32'h050, 32'h0, 5'd4, 1'b0);
        e_busy = 1'b1; e_req = 1'b0;
        step();
        #1;
        reset = 1'b1;
        drive(1'b0, NOP, 32'h0, 32'h0, 5'd0, 1'b1);
        e_req = 1'b0; e_busy = 1'b0; e_rst = 1'b1;
        bubble();
        step();
        reset = 1'b0;
        bus_ack = 1'b1; bus_rd_data = 32'hFFFF_FFFF;
        step();
        bus_ack = 1'b0;
        step();
        e_rst = 1'b0;

        nonmem(1'b1, 32'h0000_0042, 5'd21, 1'b0);
        chk("post_rst_out", 64'(mem_out), 64'h42);
        e_chk = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
